// File: rtl/game_2048_pkg.sv
// Shared 2048 definitions: move direction codes, input-controller button indices,
// FSM state encoding and the pending-command priority helpers.
package game_2048_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Move-button indices equal their direction code, so a grant index is the direction.
  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_CHEAT = 4;
  localparam int NUM_BTN   = 5;

  typedef enum logic [1:0] {
    IN_IDLE  = 2'd0,
    IN_ISSUE = 2'd1,
    IN_GAP   = 2'd2
  } in_state_e;

  // One-hot grant: cheat first, then the lowest move index.
  function automatic logic [NUM_BTN-1:0] pick_pending(input logic [NUM_BTN-1:0] pend);
    logic [NUM_BTN-1:0] grant;
    grant = '0;
    if (pend[BTN_CHEAT]) begin
      grant[BTN_CHEAT] = 1'b1;
    end else begin
      for (int i = BTN_RIGHT; i >= BTN_UP; i--) begin
        if (pend[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
    return grant;
  endfunction

  function automatic logic [1:0] grant_dir(input logic [NUM_BTN-1:0] grant);
    logic [1:0] dir;
    dir = DIR_UP;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (grant[i] && (i != BTN_CHEAT)) dir = 2'(i);
    end
    return dir;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw push-button: 2-FF synchronizer, stability-counter debounce and a registered
// rising-edge pulse that stays masked until the button is seen released after reset.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          prev_q;
  logic [1:0]    fill_q;
  logic          armed_q;
  logic          rise_q;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                   cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      // sync2 only reflects the pin once the pipeline has refilled after reset
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~sync2_q);
      rise_q  <= level_q & ~prev_q & armed_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/game_2048_input_ctrl.sv
// Button front end for game_2048_core: five debouncers, one pending bit per button and a
// priority-served IDLE/ISSUE/GAP FSM that emits spaced single-cycle commands.
module game_2048_input_ctrl
  import game_2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int GAP_CYCLES      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_up,
  input  logic               btn_left,
  input  logic               btn_down,
  input  logic               btn_right,
  input  logic               btn_cheat,
  output logic               move_valid,
  output logic [1:0]         move_dir,
  output logic               cheat_valid,
  output logic [1:0]         dbg_state,
  output logic [NUM_BTN-1:0] dbg_level
);

  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  logic [NUM_BTN-1:0] raw_btn, level_w, rise_w;
  logic [NUM_BTN-1:0] pend_q, pend_d, pend_clr, grant;
  in_state_e          state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               cmd_cheat_q, cmd_cheat_d;
  logic [1:0]         cmd_dir_q, cmd_dir_d;

  assign raw_btn = {btn_cheat, btn_right, btn_down, btn_left, btn_up};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_btn[g]),
      .level  (level_w[g]),
      .rise   (rise_w[g])
    );
  end

  assign grant = pick_pending(pend_q);

  // A rise landing on the cycle its own bit is served re-queues it as a fresh press.
  assign pend_d = (pend_q & ~pend_clr) | rise_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IN_IDLE;
      gap_q       <= '0;
      pend_q      <= '0;
      cmd_cheat_q <= 1'b0;
      cmd_dir_q   <= DIR_UP;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      pend_q      <= pend_d;
      cmd_cheat_q <= cmd_cheat_d;
      cmd_dir_q   <= cmd_dir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    cmd_cheat_d = cmd_cheat_q;
    cmd_dir_d   = cmd_dir_q;
    pend_clr    = '0;
    unique case (state_q)
      IN_IDLE: begin
        if (|pend_q) begin
          pend_clr    = grant;
          cmd_cheat_d = grant[BTN_CHEAT];
          cmd_dir_d   = grant_dir(grant);
          state_d     = IN_ISSUE;
        end
      end
      IN_ISSUE: begin
        gap_d   = GW'(GAP_CYCLES - 1);
        state_d = IN_GAP;
      end
      IN_GAP: begin
        if (gap_q == '0) state_d = IN_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IN_IDLE;
    endcase
  end

  always_comb begin
    move_valid  = 1'b0;
    cheat_valid = 1'b0;
    move_dir    = DIR_UP;
    if (state_q == IN_ISSUE) begin
      if (cmd_cheat_q) begin
        cheat_valid = 1'b1;
      end else begin
        move_valid = 1'b1;
        move_dir   = cmd_dir_q;
      end
    end
  end

  assign dbg_state = state_q;
  assign dbg_level = level_w;

endmodule

// File: tb/tb_game_2048_input_ctrl.sv
// Bench for game_2048_input_ctrl: press-level reference model feeding an expected pulse
// queue, a negedge monitor feeding an observed queue, and directed plus random scenarios.
module tb_game_2048_input_ctrl;

  localparam int DEB = 8;
  localparam int GAP = 4;
  localparam int W   = 20;  // {cycle[15:0], cheat, move, dir[1:0]}

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_up = 1'b0, btn_left = 1'b0, btn_down = 1'b0, btn_right = 1'b0, btn_cheat = 1'b0;
  logic       move_valid, cheat_valid;
  logic [1:0] move_dir;
  logic [1:0] dbg_state;
  logic [4:0] dbg_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  game_2048_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_up     (btn_up),
    .btn_left   (btn_left),
    .btn_down   (btn_down),
    .btn_right  (btn_right),
    .btn_cheat  (btn_cheat),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .cheat_valid(cheat_valid),
    .dbg_state  (dbg_state),
    .dbg_level  (dbg_level)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A button press is 8 consecutive samples differing from its debounced level; it
  // becomes a pending command 4 edges after its 8th sample. Commands leave one per
  // slot, slots at least GAP+2 edges apart, cheat first then up/left/down/right.
  int m_edge, m_last;
  bit m_lvl[5];
  bit m_arm[5];
  bit m_pend[5];
  int m_run[5];
  int m_due[5];

  task automatic model_clear();
    m_edge = 0;
    m_last = -100;
    for (int i = 0; i < 5; i++) begin
      m_lvl[i] = 1'b0; m_arm[i] = 1'b0; m_pend[i] = 1'b0; m_run[i] = 0; m_due[i] = -1;
    end
  endtask

  task automatic model_edge();
    logic [4:0] raw;
    logic [1:0] dir;
    int         win;
    raw = {btn_cheat, btn_right, btn_down, btn_left, btn_up};
    m_edge++;
    win = -1;
    if (m_edge - m_last >= GAP + 2) begin
      if (m_pend[4]) win = 4;
      else for (int i = 3; i >= 0; i--) if (m_pend[i]) win = i;
    end
    if (win >= 0) begin
      m_pend[win] = 1'b0;
      m_last      = m_edge;
      dir         = (win == 4) ? 2'd0 : 2'(win);
      exp_q.push_back({cyc[15:0], (win == 4), (win != 4), dir});
    end
    for (int i = 0; i < 5; i++) begin
      if (m_due[i] == m_edge) begin
        m_pend[i] = 1'b1;
        m_due[i]  = -1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (!raw[i]) m_arm[i] = 1'b1;
      if (raw[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = raw[i];
          m_run[i] = 0;
          if (m_lvl[i] && m_arm[i]) m_due[i] = m_edge + 4;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else begin
        cyc++;
        model_edge();
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && (move_valid || cheat_valid || move_dir != 2'd0))
        obs_q.push_back({cyc[15:0], cheat_valid, move_valid, move_dir});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_btns(input logic [4:0] v);  // {cheat,right,down,left,up}
    {btn_cheat, btn_right, btn_down, btn_left, btn_up} = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    logic [W-1:0] e, o;
    reset_n = 1'b0;
    drive_btns(5'($urandom_range(0, 31)));
    for (int k = 0; k < 3; k++) begin
      wait_cyc(1);
      checks++;
      if ({move_valid, cheat_valid, move_dir} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs: got mv=%b cv=%b dir=%0d, required all 0", move_valid, cheat_valid, move_dir);
      end
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    exp_q.delete(); obs_q.delete();
    drive_btns(5'b00100);  // down held across release
    reset_n = 1'b1;
    wait_cyc(30);
    drive_btns(5'b00000);
    wait_cyc(20);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL held_through_reset: got %0d pulses, required 0", obs_q.size());
    end
    drive_btns(5'b00100);  // fresh press now counts
    wait_cyc(20);
    drive_btns(5'b00000);
    wait_cyc(20);
    n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL fresh_press_count: got %0d pulses, required 1", n);
    end
    for (int k = 0; k < n; k++) begin
      e = (k < exp_q.size()) ? exp_q[k] : '1;
      o = (k < obs_q.size()) ? obs_q[k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_scoreboard[%0d]: got %h, required %h", k, o, e); end
    end
  endtask

  task automatic test_clean_press();
    int s, n;
    logic [W-1:0] e, o, want;
    exp_q.delete(); obs_q.delete();
    s = cyc + 1;
    drive_btns(5'b00010);
    wait_cyc(20);
    drive_btns(5'b00000);
    wait_cyc(30);
    want = {16'(s + 12), 1'b0, 1'b1, 2'd1};
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== want) begin
      errors++;
      $display("FAIL clean_press: got %0d pulses first=%h, required 1 pulse %h", obs_q.size(), obs_q[0], want);
    end
    n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int k = 0; k < n; k++) begin
      e = (k < exp_q.size()) ? exp_q[k] : '1;
      o = (k < obs_q.size()) ? obs_q[k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL clean_scoreboard[%0d]: got %h, required %h", k, o, e); end
    end
  endtask

  task automatic test_bounce();
    int s, n;
    logic [W-1:0] e, o, want;
    exp_q.delete(); obs_q.delete();
    s = cyc + 1;
    for (int k = 0; k < 30; k++) begin
      btn_up = ((k / 3) % 2 == 0);
      wait_cyc(1);
    end
    btn_up = 1'b1;  // final rise sampled at s+30
    wait_cyc(25);
    btn_up = 1'b0;
    wait_cyc(30);
    want = {16'(s + 42), 1'b0, 1'b1, 2'd0};
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== want) begin
      errors++;
      $display("FAIL bounce: got %0d pulses first=%h, required 1 pulse %h", obs_q.size(), obs_q[0], want);
    end
    n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int k = 0; k < n; k++) begin
      e = (k < exp_q.size()) ? exp_q[k] : '1;
      o = (k < obs_q.size()) ? obs_q[k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL bounce_scoreboard[%0d]: got %h, required %h", k, o, e); end
    end
  endtask

  task automatic test_simultaneous();
    int s;
    logic [W-1:0] w0, w1;
    exp_q.delete(); obs_q.delete();
    s = cyc + 1;
    drive_btns(5'b01001);  // up + right
    wait_cyc(20);
    drive_btns(5'b00000);
    wait_cyc(30);
    w0 = {16'(s + 12), 1'b0, 1'b1, 2'd0};
    w1 = {16'(s + 18), 1'b0, 1'b1, 2'd3};
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== w0 || obs_q[1] !== w1) begin
      errors++;
      $display("FAIL simultaneous: got n=%0d %h %h, required %h %h", obs_q.size(), obs_q[0], obs_q[1], w0, w1);
    end
    checks++;
    if (obs_q != exp_q) begin
      errors++;
      $display("FAIL simultaneous_scoreboard: got n=%0d, required n=%0d matching", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_cheat_priority();
    int s;
    logic [W-1:0] w0, w1;
    exp_q.delete(); obs_q.delete();
    s = cyc + 1;
    drive_btns(5'b10100);  // cheat + down
    wait_cyc(20);
    drive_btns(5'b00000);
    wait_cyc(30);
    w0 = {16'(s + 12), 1'b1, 1'b0, 2'd0};
    w1 = {16'(s + 18), 1'b0, 1'b1, 2'd2};
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== w0 || obs_q[1] !== w1) begin
      errors++;
      $display("FAIL cheat_priority: got n=%0d %h %h, required %h %h", obs_q.size(), obs_q[0], obs_q[1], w0, w1);
    end
    checks++;
    if (obs_q != exp_q) begin
      errors++;
      $display("FAIL cheat_scoreboard: got n=%0d, required n=%0d matching", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_queue_during_gap();
    int s;
    logic [W-1:0] w0, w1;
    exp_q.delete(); obs_q.delete();
    s = cyc + 1;
    drive_btns(5'b00010);  // left
    wait_cyc(4);
    drive_btns(5'b01010);  // right rises 4 cycles later -> debounced 2 after the left pulse
    wait_cyc(20);
    drive_btns(5'b00000);
    wait_cyc(30);
    w0 = {16'(s + 12), 1'b0, 1'b1, 2'd1};
    w1 = {16'(s + 18), 1'b0, 1'b1, 2'd3};
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== w0 || obs_q[1] !== w1) begin
      errors++;
      $display("FAIL queue_during_gap: got n=%0d %h %h, required %h %h", obs_q.size(), obs_q[0], obs_q[1], w0, w1);
    end
    checks++;
    if (obs_q != exp_q) begin
      errors++;
      $display("FAIL queue_scoreboard: got n=%0d, required n=%0d matching", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_gap();
    int s;
    logic [W-1:0] w0;
    exp_q.delete(); obs_q.delete();
    s = cyc + 1;
    drive_btns(5'b00011);  // up + left; left waits behind up
    wait_cyc(15);          // now two edges past the up pulse, FSM in gap
    reset_n = 1'b0;
    drive_btns(5'b00000);
    #1;
    checks++;
    if ({move_valid, cheat_valid, move_dir} !== 4'b0000 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_gap_reset_now: got mv=%b cv=%b dir=%0d st=%0d, required all 0", move_valid, cheat_valid, move_dir, dbg_state);
    end
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(40);
    w0 = {16'(s + 12), 1'b0, 1'b1, 2'd0};
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== w0) begin
      errors++;
      $display("FAIL reset_mid_gap: got n=%0d first=%h, required 1 pulse %h", obs_q.size(), obs_q[0], w0);
    end
    checks++;
    if (obs_q != exp_q) begin
      errors++;
      $display("FAIL reset_mid_gap_scoreboard: got n=%0d, required n=%0d matching", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    int n;
    logic [4:0] v;
    logic [W-1:0] e, o;
    exp_q.delete(); obs_q.delete();
    v = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 9) == 0) v[b] = ~v[b];
      drive_btns(v);
      wait_cyc(1);
    end
    drive_btns(5'b00000);
    wait_cyc(60);
    checks++;
    if (exp_q.size() < 5) begin
      errors++;
      $display("FAIL random_activity: got %0d expected pulses, required at least 5", exp_q.size());
    end
    n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int k = 0; k < n; k++) begin
      e = (k < exp_q.size()) ? exp_q[k] : '1;
      o = (k < obs_q.size()) ? obs_q[k] : '1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL random_scoreboard[%0d]: got %h, required %h", k, o, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_cheat_priority();
    test_queue_during_gap();
    test_reset_mid_gap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
